// File: rtl/multiboot_pkg.sv
// multiboot_pkg: state encoding, default unlock key and minimum pulse width
// shared by the multiboot request controller and its bench.
package multiboot_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNLOCK    = 3'd1,
    WAIT_IDLE = 3'd2,
    DELAY     = 3'd3,
    FIRE      = 3'd4,
    DONE      = 3'd5
  } state_t;
  localparam logic [7:0] KEY0_DEF = 8'hB0;
  localparam logic [7:0] KEY1_DEF = 8'h07;
  localparam int MIN_PULSE = 3;
endpackage

// File: rtl/mb_down_counter.sv
// mb_down_counter: loadable saturating down-counter with a zero flag.
module mb_down_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_value;
    else if (dec && !zero) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/multiboot_request_ctrl.sv
// multiboot_request_ctrl: two-byte unlock, flash-idle gate and settle delay, then one
// trigger pulse and lockout until reset. Define MULTIBOOT_REQ_ABORT_EN to add an abort input.
module multiboot_request_ctrl
  import multiboot_pkg::*;
#(
  parameter logic [7:0] KEY0         = KEY0_DEF,
  parameter logic [7:0] KEY1         = KEY1_DEF,
  parameter int         ARM_TIMEOUT  = 65535,
  parameter int         DELAY_CYCLES = 1000,
  parameter int         PULSE_CYCLES = 4,
  parameter int         CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       flash_busy,
  output logic       trigger,
  output logic [2:0] state_o,
`ifdef MULTIBOOT_REQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       timeout_o
);
  localparam logic [CNT_W-1:0] ARM_V = CNT_W'(ARM_TIMEOUT);
  localparam logic [CNT_W-1:0] DLY_V = CNT_W'(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] PUL_V = CNT_W'(PULSE_CYCLES - 1);
  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (PULSE_CYCLES < MIN_PULSE) begin : g_pulse_chk
    $error("PULSE_CYCLES is below the minimum pulse width");
  end
  if (longint'(ARM_TIMEOUT) >= CNT_LIM || longint'(DELAY_CYCLES) >= CNT_LIM ||
      longint'(PULSE_CYCLES - 1) >= CNT_LIM) begin : g_width_chk
    $error("counter reload value does not fit in CNT_W bits");
  end

  state_t state, next;
  logic acc, expire, kill, ld, dec, zero, ready_d, trig_d;
  logic [CNT_W-1:0] ld_val;

  assign acc = cmd_valid & cmd_ready;
  assign expire = state == UNLOCK && !acc && zero;
`ifdef MULTIBOOT_REQ_ABORT_EN
  assign kill = abort && state inside {UNLOCK, WAIT_IDLE, DELAY};
`else
  assign kill = 1'b0;
`endif
  assign state_o = state;

  mb_down_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .load_value (ld_val),
    .dec        (dec),
    .zero       (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      trigger   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= next;
      cmd_ready <= ready_d;
      trigger   <= trig_d;
      timeout_o <= expire;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:      next = acc && cmd_data == KEY0 ? UNLOCK : IDLE;
      UNLOCK:    next = acc ? (cmd_data == KEY1 ? WAIT_IDLE : cmd_data == KEY0 ? UNLOCK : IDLE)
                            : (zero ? IDLE : UNLOCK);
      WAIT_IDLE: next = flash_busy ? WAIT_IDLE : DELAY;
      DELAY:     next = flash_busy ? WAIT_IDLE : zero ? FIRE : DELAY;
      FIRE:      next = zero ? DONE : FIRE;
      DONE:      next = DONE;
      default:   next = IDLE;
    endcase
    if (kill) next = IDLE;
  end

  // One counter serves all phases: every entering transition reloads it.
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    dec    = 1'b0;
    case (state)
      IDLE:      begin ld = acc && cmd_data == KEY0; ld_val = ARM_V; end
      UNLOCK:    begin ld = acc && cmd_data == KEY0; ld_val = ARM_V; dec = 1'b1; end
      WAIT_IDLE: begin ld = !flash_busy; ld_val = DLY_V; end
      DELAY:     begin ld = !flash_busy && zero; ld_val = PUL_V; dec = !flash_busy; end
      FIRE:      dec = 1'b1;
      default:   ;
    endcase
    ready_d = next inside {IDLE, UNLOCK};
    trig_d  = next == FIRE;
  end
endmodule

// File: tb/tb_multiboot_request_ctrl.sv
// tb_multiboot_request_ctrl: timestamp-based reference model compared every cycle,
// directed scenarios with literal timing checks, then randomized traffic.
module tb_multiboot_request_ctrl;
  localparam int ARM = 50;
  localparam int DLY = 10;
  localparam int PUL = 4;
  localparam logic [7:0] K0 = 8'hB0;
  localparam logic [7:0] K1 = 8'h07;

  logic clk = 0, rst = 1, cmd_valid = 0, flash_busy = 0;
  logic [7:0] cmd_data = 0;
  logic cmd_ready, trigger, timeout_o;
  logic [2:0] state_o;
`ifdef MULTIBOOT_REQ_ABORT_EN
  logic abort = 0;
`endif

  int tests = 0, fails = 0, cyc = 0, trig_cnt = 0;
  int m_ph = 0, m_ta = 0, m_ti = 0, m_tf = 0, m_tk0 = 0, m_tk1 = 0;
  logic m_tmo = 0;

  always #5 clk = ~clk;

  multiboot_request_ctrl #(
    .ARM_TIMEOUT (ARM),
    .DELAY_CYCLES(DLY),
    .PULSE_CYCLES(PUL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .flash_busy(flash_busy),
    .trigger   (trigger),
    .state_o   (state_o),
`ifdef MULTIBOOT_REQ_ABORT_EN
    .abort     (abort),
`endif
    .timeout_o (timeout_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: phases with timestamps of the events that start each timed window.
  always @(posedge clk) begin : model
    int ph, ta, ti, tf, e;
    logic tmo, acc;
    e = cyc + 1; ph = m_ph; ta = m_ta; ti = m_ti; tf = m_tf; tmo = 0;
    acc = cmd_valid && m_ph <= 1;
    if (rst) ph = 0;
    else begin
      case (m_ph)
        0: if (acc && cmd_data == K0) begin ph = 1; ta = e; end
        1: if (acc) begin
             if (cmd_data == K1) ph = 2;
             else if (cmd_data == K0) ta = e;
             else ph = 0;
           end else if (e - ta == ARM + 1) begin ph = 0; tmo = 1; end
        2: if (!flash_busy) begin ph = 3; ti = e; end
        3: if (flash_busy) ph = 2;
           else if (e - ti == DLY + 1) begin ph = 4; tf = e; end
        4: if (e - tf == PUL) ph = 5;
        default: ;
      endcase
`ifdef MULTIBOOT_REQ_ABORT_EN
      if (abort && m_ph >= 1 && m_ph <= 3) ph = 0;
`endif
      if (acc && cmd_data == K0) m_tk0 <= e;
      if (acc && m_ph == 1 && cmd_data == K1) m_tk1 <= e;
    end
    m_ph <= ph; m_ta <= ta; m_ti <= ti; m_tf <= tf; m_tmo <= tmo; cyc <= e;
  end

  always @(negedge clk) begin
    if (trigger) trig_cnt++;
    if (cyc > 0) begin
      chk("state_o", state_o, m_ph);
      chk("trigger", trigger, m_ph == 4);
      chk("cmd_ready", cmd_ready, m_ph <= 1);
      chk("timeout_o", timeout_o, m_tmo);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); cmd_valid = 1; cmd_data = b;
    @(negedge clk); cmd_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic wait_sig(input bit tmo_sel, output int t, output bit ok);
    ok = 0; t = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (tmo_sel ? timeout_o : trigger) begin ok = 1; t = cyc; end
    end
  endtask

  task automatic pulse_width(output int w);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trigger) w++; else break;
    end
  endtask

  initial begin
    int t, w, c0, tl;
    bit ok;
    idle(3);
    rst = 0;
    chk("rst_state", state_o, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_trigger", trigger, 0);
    chk("rst_timeout", timeout_o, 0);

    // Nominal unlock and fire, then lockout
    send(K0); send(K1);
    wait_sig(0, t, ok);
    chk("t1_fired", ok, 1);
    chk("t1_latency", t - m_tk1, 12);
    pulse_width(w);
    chk("t1_width", w, 4);
    chk("t1_done_state", state_o, 5);
    c0 = trig_cnt;
    send(K0); send(K1); idle(40);
    chk("t1_no_retrigger", trig_cnt - c0, 0);
    chk("t1_still_done", state_o, 5);
    do_reset();

    // Unlock window expiry
    c0 = trig_cnt;
    send(K0);
    wait_sig(1, t, ok);
    chk("t2_timeout_seen", ok, 1);
    chk("t2_timeout_at", t - m_tk0, 51);
    chk("t2_idle_after", state_o, 0);
    idle(1);
    chk("t2_timeout_one_cycle", timeout_o, 0);
    chk("t2_no_trigger", trig_cnt - c0, 0);

    // Wrong second byte
    send(K0); send(8'h3C);
    chk("t3_back_idle", state_o, 0);
    idle(60);
    chk("t3_no_trigger", trig_cnt - c0, 0);

    // Repeated KEY0 restarts the window
    send(K0); send(K0); send(K1);
    wait_sig(0, t, ok);
    chk("t4_fired", ok, 1);
    chk("t4_latency", t - m_tk1, 12);
    idle(6);
    do_reset();

    // Flash busy gating and delay restart
    c0 = trig_cnt;
    @(negedge clk); flash_busy = 1;
    send(K0); send(K1); idle(100);
    chk("t5_no_trigger_busy", trig_cnt - c0, 0);
    chk("t5_wait_state", state_o, 2);
    flash_busy = 0;
    idle(5);
    chk("t5_in_delay", state_o, 3);
    flash_busy = 1;
    idle(3);
    chk("t5_back_wait", state_o, 2);
    flash_busy = 0; tl = cyc + 1;
    wait_sig(0, t, ok);
    chk("t5_fired", ok, 1);
    chk("t5_latency_from_idle", t - tl, 11);
    idle(6);
    do_reset();

    // Reset in the second FIRE cycle
    send(K0); send(K1);
    wait_sig(0, t, ok);
    chk("t6_fired", ok, 1);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("t6_trigger_low", trigger, 0);
    chk("t6_state_idle", state_o, 0);
    chk("t6_ready", cmd_ready, 1);
    send(K0); send(K1);
    wait_sig(0, t, ok);
    chk("t6_refire", ok, 1);
    chk("t6_refire_latency", t - m_tk1, 12);
    idle(6);

`ifdef MULTIBOOT_REQ_ABORT_EN
    do_reset();
    c0 = trig_cnt;
    send(K0); send(K1); idle(3);
    chk("t7_in_delay", state_o, 3);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("t7_abort_idle", state_o, 0);
    idle(20);
    chk("t7_no_trigger", trig_cnt - c0, 0);
    send(K0); send(K1);
    wait_sig(0, t, ok);
    chk("t7_fired", ok, 1);
    w = 1;
    for (int i = 0; i < 20; i++) begin
      abort = i == 0;
      @(negedge clk);
      if (trigger) w++; else break;
    end
    abort = 0;
    chk("t7_abort_in_fire_width", w, 4);
    do_reset();
`else
    do_reset();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      cmd_valid = $urandom % 3 == 0;
      case ($urandom % 4)
        0: cmd_data = K0;
        1: cmd_data = K1;
        2: cmd_data = 8'h3C;
        default: cmd_data = 8'($urandom);
      endcase
      if ($urandom % 25 == 0) flash_busy = ~flash_busy;
      rst = $urandom % 250 == 0;
`ifdef MULTIBOOT_REQ_ABORT_EN
      abort = $urandom % 120 == 0;
`endif
    end
    @(negedge clk);
    cmd_valid = 0; rst = 0; flash_busy = 0;
`ifdef MULTIBOOT_REQ_ABORT_EN
    abort = 0;
`endif
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
